// File: rtl/sram_port_arbiter.sv
// Shares one synchronous SRAM port among NUM_CH valid/ready requesters and returns read data
// (or a zero write ack) to the issuing channel exactly RD_LAT cycles after acceptance.
module sram_port_arbiter #(
   parameter int  NUM_CH     = 2,
   parameter int  ADDR_W     = 32,
   parameter int  DATA_W     = 32,
   parameter int  RD_LAT     = 1,
   parameter int  RR_MODE    = 0,
   parameter int  STARVE_MAX = 8,
   localparam int BE_W       = DATA_W / 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        req_valid,
   output logic [NUM_CH-1:0]        req_ready,
   input  logic [NUM_CH*BE_W-1:0]   req_we,
   input  logic [NUM_CH*ADDR_W-1:0] req_addr,
   input  logic [NUM_CH*DATA_W-1:0] req_wdata,
   output logic [NUM_CH-1:0]        rsp_valid,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     sram_en,
   output logic [BE_W-1:0]          sram_we,
   output logic [ADDR_W-1:0]        sram_addr,
   output logic [DATA_W-1:0]        sram_wdata,
   input  logic [DATA_W-1:0]        sram_rdata
);

   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int CNT_W = $clog2(STARVE_MAX + 1);

   logic [CH_W-1:0]   rr_ptr;
   logic [CNT_W-1:0]  starve_cnt [NUM_CH];
   logic [NUM_CH-1:0] forced;
   logic [NUM_CH-1:0] is_write;
   logic              grant_any;
   logic [CH_W-1:0]   grant_idx;
   logic              grant_write;
   logic [RD_LAT-1:0] tag_valid;
   logic [RD_LAT-1:0] tag_read;
   logic [CH_W-1:0]   tag_ch [RD_LAT];

   // Per-channel request class and starvation flag; the flag holds while the counter sits saturated.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         is_write[i] = |req_we[i*BE_W +: BE_W];
         forced[i]   = (RR_MODE == 0) && (starve_cnt[i] == CNT_W'(STARVE_MAX));
      end
   end

   // Grant selection, combinational from the current requests.
   always_comb begin
      int idx;
      grant_any = 1'b0;
      grant_idx = '0;
      idx       = 0;
      if (RR_MODE != 0) begin
         for (int k = 0; k < NUM_CH; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_CH;
            if (!grant_any && req_valid[idx]) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(idx);
            end
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_any && req_valid[i] && forced[i]) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(i);
            end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_any && req_valid[i] && is_write[i]) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(i);
            end
         end
         for (int i = 0; i < NUM_CH; i++) begin
            if (!grant_any && req_valid[i]) begin
               grant_any = 1'b1;
               grant_idx = CH_W'(i);
            end
         end
      end
      if (!reset) begin
         grant_any = 1'b0;
      end
   end

   // Drive the SRAM port straight from the granted channel in the grant cycle.
   always_comb begin
      req_ready   = '0;
      sram_en     = 1'b0;
      sram_we     = '0;
      sram_addr   = '0;
      sram_wdata  = '0;
      grant_write = 1'b0;
      if (grant_any) begin
         req_ready[grant_idx] = 1'b1;
         sram_en              = 1'b1;
         sram_we              = req_we[int'(grant_idx)*BE_W +: BE_W];
         sram_addr            = req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
         sram_wdata           = req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
         grant_write          = |req_we[int'(grant_idx)*BE_W +: BE_W];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_CH; i++) begin
            starve_cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (!req_valid[i] || req_ready[i]) begin
               starve_cnt[i] <= '0;
            end else if (starve_cnt[i] != CNT_W'(STARVE_MAX)) begin
               starve_cnt[i] <= starve_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr <= '0;
      end else if (grant_any) begin
         rr_ptr <= (grant_idx == CH_W'(NUM_CH - 1)) ? '0 : grant_idx + 1'b1;
      end
   end

   // One tag per accepted transfer; at most one accept per cycle, so the shift register never backs up.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tag_valid <= '0;
         tag_read  <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            tag_ch[s] <= '0;
         end
      end else begin
         tag_valid[0] <= grant_any;
         tag_read[0]  <= grant_any && !grant_write;
         tag_ch[0]    <= grant_idx;
         for (int s = 1; s < RD_LAT; s++) begin
            tag_valid[s] <= tag_valid[s-1];
            tag_read[s]  <= tag_read[s-1];
            tag_ch[s]    <= tag_ch[s-1];
         end
      end
   end

   always_comb begin
      rsp_valid = '0;
      rsp_rdata = '0;
      if (tag_valid[RD_LAT-1]) begin
         rsp_valid[tag_ch[RD_LAT-1]] = 1'b1;
         if (tag_read[RD_LAT-1]) begin
            rsp_rdata = sram_rdata;
         end
      end
   end

endmodule
